// File: rtl/hb_pkg.sv
// Shared types and elaboration helpers for the halfband MAC sequencer.
package hb_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_PAIR, ST_CENTER, ST_DRAIN, ST_OUT} state_t;

  localparam int NTAPS_DEF   = 11;
  localparam int AW_DEF      = 4;
  localparam int MAC_LAT_DEF = 2;

  function automatic int k_of(input int ntaps);
    return (ntaps + 1) / 4;
  endfunction

  function automatic int ciw_of(input int ntaps);
    return $clog2(k_of(ntaps) + 1);
  endfunction

  localparam int K   = k_of(NTAPS_DEF);
  localparam int CIW = ciw_of(NTAPS_DEF);

  // Tap j of the delay line: newest sample minus j, wrapping in the RAM width.
  function automatic logic [31:0] tap_addr(input logic [31:0] base, input int j, input int aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (base - 32'(j)) & mask;
  endfunction

  function automatic bit ntaps_ok(input int ntaps);
    return (ntaps >= 3) && (ntaps % 4 == 3);
  endfunction

  function automatic bit aw_ok(input int ntaps, input int aw);
    return (1 << aw) >= (ntaps + 1);
  endfunction

endpackage

// File: rtl/hb_ring_ptr.sv
// Circular sample RAM write pointer, decimation phase, trigger and latched base.
module hb_ring_ptr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_in_valid,
  input  logic          accept,
  output logic [AW-1:0] wr_ptr,
  output logic          trigger,
  output logic [AW-1:0] base
);

  logic phase;

  assign trigger = x_in_valid & phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      phase  <= 1'b0;
      base   <= '0;
    end else begin
      if (x_in_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= ~phase;
      end
      // A dropped trigger must not disturb the base of the running computation.
      if (trigger && accept) base <= wr_ptr;
    end
  end

endmodule

// File: rtl/hb_mac_sched.sv
// Sequencer for a serial single-multiplier halfband decimate-by-2 filter.
module hb_mac_sched
  import hb_pkg::*;
#(
  parameter  int NTAPS   = NTAPS_DEF,
  parameter  int AW      = AW_DEF,
  parameter  int MAC_LAT = MAC_LAT_DEF,
  localparam int NPAIR   = k_of(NTAPS),
  localparam int CW      = ciw_of(NTAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_in_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [CW-1:0] coef_idx,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_center,
  output logic          y_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  if (!ntaps_ok(NTAPS)) begin : g_bad_ntaps
    $error("hb_mac_sched: NTAPS must satisfy NTAPS mod 4 == 3");
  end
  if (!aw_ok(NTAPS, AW)) begin : g_bad_aw
    $error("hb_mac_sched: 2**AW must be at least NTAPS+1");
  end
  if (MAC_LAT < 1) begin : g_bad_lat
    $error("hb_mac_sched: MAC_LAT must be at least 1");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] base;
  logic          trigger;
  logic          accept;

  function automatic logic [AW-1:0] tap(input logic [AW-1:0] b, input int j);
    return AW'(tap_addr(32'(b), j, AW));
  endfunction

  assign accept  = (state == ST_IDLE) || (state == ST_OUT);
  assign wr_en   = x_in_valid & ~reset;
  assign wr_addr = wr_ptr;

  hb_ring_ptr #(.AW(AW)) u_ring (
    .clk        (clk),
    .reset      (reset),
    .x_in_valid (x_in_valid),
    .accept     (accept),
    .wr_ptr     (wr_ptr),
    .trigger    (trigger),
    .base       (base)
  );

  // Outputs are computed for the state being entered, so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dcnt       <= '0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      coef_idx   <= '0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      mac_center <= 1'b0;
      y_valid    <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      coef_idx   <= '0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      mac_center <= 1'b0;
      y_valid    <= 1'b0;
      if (trigger && !accept) overrun <= 1'b1;
      case (state)
        ST_IDLE, ST_OUT: begin
          if (trigger) begin
            // base is latched this same edge, so PAIR0 addresses come from wr_ptr.
            state     <= ST_PAIR;
            cnt       <= '0;
            busy      <= 1'b1;
            rd_addr_a <= wr_ptr;
            rd_addr_b <= tap(wr_ptr, NTAPS - 1);
            mac_en    <= 1'b1;
            mac_clr   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_PAIR: begin
          mac_en <= 1'b1;
          if (cnt == CW'(NPAIR - 1)) begin
            state      <= ST_CENTER;
            rd_addr_a  <= tap(base, (NTAPS - 1) / 2);
            coef_idx   <= CW'(NPAIR);
            mac_center <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            rd_addr_a <= tap(base, 2 * (int'(cnt) + 1));
            rd_addr_b <= tap(base, NTAPS - 3 - 2 * int'(cnt));
            coef_idx  <= cnt + 1'b1;
          end
        end
        ST_CENTER: begin
          state <= ST_DRAIN;
          dcnt  <= '0;
        end
        ST_DRAIN: begin
          if (dcnt == DW'(MAC_LAT - 1)) begin
            state   <= ST_OUT;
            y_valid <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hb_mac_sched.sv
// Directed and random bench for hb_mac_sched against a cycle-offset reference model.
module tb_hb_mac_sched;

  localparam int NT  = 11;
  localparam int ML  = 2;
  localparam int K   = (NT + 1) / 4;
  localparam int LAT = K + 2 + ML;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x_in_valid = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [1:0] coef_idx;
  logic       mac_clr, mac_en, mac_center, y_valid, busy, overrun;

  hb_mac_sched dut (
    .clk(clk), .reset(reset), .x_in_valid(x_in_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .coef_idx(coef_idx), .mac_clr(mac_clr),
    .mac_en(mac_en), .mac_center(mac_center), .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_trig = -100000;
  int mbase = 0;
  int wp = 0;
  bit ph = 1'b0;
  bit movr = 1'b0;
  int ycount = 0;

  function automatic int m16(input int x);
    return ((x % 16) + 16) % 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: cyc=%0d got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs follow from the cycle distance to the last accepted trigger.
  task automatic check_cycle();
    int  d;
    bit  in_pair, in_ctr;
    d = cyc - last_trig;
    in_pair = (d >= 1) && (d <= K);
    in_ctr  = (d == K + 1);
    chk("busy", 32'(busy), 32'((d >= 1) && (d <= LAT)));
    chk("y_valid", 32'(y_valid), 32'(d == LAT));
    chk("mac_en", 32'(mac_en), 32'(in_pair || in_ctr));
    chk("mac_clr", 32'(mac_clr), 32'(d == 1));
    chk("mac_center", 32'(mac_center), 32'(in_ctr));
    chk("overrun", 32'(overrun), 32'(movr));
    if (in_pair) begin
      chk("pair_a", 32'(rd_addr_a), 32'(m16(mbase - 2 * (d - 1))));
      chk("pair_b", 32'(rd_addr_b), 32'(m16(mbase - (NT - 1 - 2 * (d - 1)))));
      chk("pair_coef", 32'(coef_idx), 32'(d - 1));
    end
    if (in_ctr) begin
      chk("ctr_a", 32'(rd_addr_a), 32'(m16(mbase - (NT - 1) / 2)));
      chk("ctr_coef", 32'(coef_idx), 32'(K));
    end
    if (y_valid) ycount++;
  endtask

  task automatic tick(input bit v);
    reset = 1'b0;
    x_in_valid = v;
    #1;
    chk("wr_en", 32'(wr_en), 32'(v));
    chk("wr_addr", 32'(wr_addr), 32'(wp));
    if (v && ph) begin
      if (cyc - last_trig >= LAT) begin
        last_trig = cyc;
        mbase = wp;
      end else begin
        movr = 1'b1;
      end
    end
    if (v) begin
      wp = (wp + 1) % 16;
      ph = !ph;
    end
    @(posedge clk); #1;
    cyc++;
    x_in_valid = 1'b0;
    check_cycle();
  endtask

  task automatic do_reset(input bit v);
    reset = 1'b1;
    x_in_valid = v;
    #1;
    chk("wr_en_rst", 32'(wr_en), 32'd0);
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
    x_in_valid = 1'b0;
    wp = 0; ph = 1'b0; movr = 1'b0; last_trig = -100000;
    check_cycle();
    chk("rst_a", 32'(rd_addr_a), 32'd0);
    chk("rst_b", 32'(rd_addr_b), 32'd0);
    chk("rst_coef", 32'(coef_idx), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    int y0;
    #2;
    // 1: first trigger, base = 1
    do_reset(1'b1);
    tick(1'b1); idle(11); tick(1'b1);
    chk("t1_p0_a", 32'(rd_addr_a), 32'd1);
    chk("t1_p0_b", 32'(rd_addr_b), 32'd7);
    chk("t1_p0_clr", 32'(mac_clr), 32'd1);
    tick(1'b0);
    chk("t1_p1_a", 32'(rd_addr_a), 32'd15);
    chk("t1_p1_b", 32'(rd_addr_b), 32'd9);
    tick(1'b0);
    chk("t1_p2_a", 32'(rd_addr_a), 32'd13);
    chk("t1_p2_b", 32'(rd_addr_b), 32'd11);
    tick(1'b0);
    chk("t1_ctr_a", 32'(rd_addr_a), 32'd12);
    chk("t1_ctr_coef", 32'(coef_idx), 32'd3);
    chk("t1_ctr_mc", 32'(mac_center), 32'd1);
    idle(3);
    chk("t1_yv_t7", 32'(y_valid), 32'd1);
    idle(5);

    // 2: 100 valids at 12-clock spacing
    do_reset(1'b0);
    y0 = ycount;
    for (int n = 0; n < 100; n++) begin
      tick(1'b1); idle(11);
    end
    chk("t2_ycount", 32'(ycount - y0), 32'd50);
    chk("t2_overrun", 32'(overrun), 32'd0);

    // 3: back-to-back valids cause an overrun
    do_reset(1'b0);
    y0 = ycount;
    tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b1);
    idle(20);
    chk("t3_ycount", 32'(ycount - y0), 32'd1);
    chk("t3_overrun", 32'(overrun), 32'd1);
    do_reset(1'b0);
    chk("t3_ovr_clr", 32'(overrun), 32'd0);

    // 4: trigger lands on the OUT cycle
    tick(1'b1); tick(1'b0); tick(1'b1);
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    chk("t4_yv", 32'(y_valid), 32'd1);
    tick(1'b1);
    chk("t4_clr", 32'(mac_clr), 32'd1);
    chk("t4_ovr", 32'(overrun), 32'd0);
    idle(10);

    // 5: reset during PAIR1 aborts the computation
    do_reset(1'b0);
    y0 = ycount;
    tick(1'b1); tick(1'b1); tick(1'b0);
    chk("t5_in_p1", 32'(coef_idx), 32'd1);
    do_reset(1'b1);
    chk("t5_busy", 32'(busy), 32'd0);
    idle(10);
    chk("t5_no_y", 32'(ycount - y0), 32'd0);
    tick(1'b1);
    chk("t5_no_trig", 32'(busy), 32'd0);
    tick(1'b1);
    chk("t5_trig", 32'(busy), 32'd1);
    idle(10);

    // 6: wrap, base = 3
    do_reset(1'b0);
    for (int n = 0; n < 3; n++) begin
      tick(1'b1); idle(11);
    end
    tick(1'b1);
    chk("t6_p0_b", 32'(rd_addr_b), 32'd9);
    idle(3);
    chk("t6_ctr_a", 32'(rd_addr_a), 32'd14);
    idle(5);

    // random traffic with occasional resets
    do_reset(1'b0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
      else tick($urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
